// File: rtl/mem_access_pkg.sv
// Shared MEM-stage definitions: memop one-hot bit positions, FSM states, load decode.
// Optional build macro: UNALIGNED_LS_EN enables lwl/lwr merging.
package mem_access_pkg;

    localparam int unsigned MMOP = 12;

    localparam int unsigned MOP_LB    = 0;
    localparam int unsigned MOP_LBU   = 1;
    localparam int unsigned MOP_LH    = 2;
    localparam int unsigned MOP_LHU   = 3;
    localparam int unsigned MOP_LW    = 4;
    localparam int unsigned MOP_SB    = 5;
    localparam int unsigned MOP_SH    = 6;
    localparam int unsigned MOP_SW    = 7;
    localparam int unsigned MOP_LWL   = 8;
    localparam int unsigned MOP_LWR   = 9;
    localparam int unsigned MOP_RSV10 = 10;
    localparam int unsigned MOP_RSV11 = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } mstate_e;

    function automatic logic is_load(input logic [MMOP-1:0] op);
        logic ld;
        ld = op[MOP_LB] | op[MOP_LBU] | op[MOP_LH] | op[MOP_LHU] | op[MOP_LW];
`ifdef UNALIGNED_LS_EN
        ld = ld | op[MOP_LWL] | op[MOP_LWR];
`endif
        return ld;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Combinational little-endian load alignment and sign/zero extension.
// Optional build macro: UNALIGNED_LS_EN adds lwl/lwr merging with the rt value.
module load_align
    import mem_access_pkg::*;
(
    input  logic [MMOP-1:0] memop_i,
    input  logic [1:0]      addr_low_i,
    input  logic [31:0]     rdata_i,
`ifdef UNALIGNED_LS_EN
    input  logic [31:0]     rtvalue_i,
`endif
    output logic [31:0]     data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        unused_ok;

    // Bits not decoded here (stores, reserved, or lwl/lwr when disabled) fall through to the word.
    assign unused_ok = ^memop_i;

    always_comb begin
        unique case (addr_low_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_low_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        data_o = rdata_i;
        if (memop_i[MOP_LB])
            data_o = {{24{byte_sel[7]}}, byte_sel};
        else if (memop_i[MOP_LBU])
            data_o = {24'd0, byte_sel};
        else if (memop_i[MOP_LH])
            data_o = {{16{half_sel[15]}}, half_sel};
        else if (memop_i[MOP_LHU])
            data_o = {16'd0, half_sel};
`ifdef UNALIGNED_LS_EN
        else if (memop_i[MOP_LWL]) begin
            unique case (addr_low_i)
                2'd0:    data_o = {rdata_i[7:0],  rtvalue_i[23:0]};
                2'd1:    data_o = {rdata_i[15:0], rtvalue_i[15:0]};
                2'd2:    data_o = {rdata_i[23:0], rtvalue_i[7:0]};
                default: data_o = rdata_i;
            endcase
        end
        else if (memop_i[MOP_LWR]) begin
            unique case (addr_low_i)
                2'd0:    data_o = rdata_i;
                2'd1:    data_o = {rtvalue_i[31:24], rdata_i[31:8]};
                2'd2:    data_o = {rtvalue_i[31:16], rdata_i[31:16]};
                default: data_o = {rtvalue_i[31:8],  rdata_i[31:24]};
            endcase
        end
`endif
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: data-bus response FSM, load alignment, WB register and bypass.
// Optional build macro: UNALIGNED_LS_EN enables lwl/lwr.
module mem_access
    import mem_access_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_flush_i,
    input  logic            mem_stall_i,
    input  logic [3:0]      mem_wren_i,
    input  logic [4:0]      mem_waddr_i,
    input  logic [31:0]     mem_wdata_i,
    input  logic            mem_nofwd_i,
    input  logic [MMOP-1:0] mem_memop_i,
    input  logic [1:0]      mem_memaddr_low_i,
    input  logic [31:0]     mem_rtvalue_i,
    input  logic            mem_memreq_i,
    input  logic [31:0]     data_rdata_i,
    input  logic            data_ok_i,
    output logic [3:0]      mem_wren_o,
    output logic [4:0]      mem_waddr_o,
    output logic [31:0]     mem_wdata_o,
    output logic            mem_stallreq_o,
    output logic [31:0]     mem_wdata_bp_o,
    output logic            mem_nofwd_bp_o
);

    mstate_e     state_q, state_d;
    logic [31:0] buf_q, buf_d;
    logic [3:0]  wren_q, wren_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_ld, data_avail, kill, upd;
    logic [31:0] rd_word, aligned;

    assign is_ld   = is_load(mem_memop_i);
    assign rd_word = (state_q == ST_HOLD) ? buf_q : data_rdata_i;

    load_align u_load_align (
        .memop_i    (mem_memop_i),
        .addr_low_i (mem_memaddr_low_i),
        .rdata_i    (rd_word),
`ifdef UNALIGNED_LS_EN
        .rtvalue_i  (mem_rtvalue_i),
`endif
        .data_o     (aligned)
    );

`ifndef UNALIGNED_LS_EN
    logic unused_ok;
    assign unused_ok = ^mem_rtvalue_i;
`endif

    // Stallreq drops in the response cycle itself so the WB register can take the word then.
    always_comb begin
        state_d        = state_q;
        buf_d          = buf_q;
        data_avail     = 1'b0;
        mem_stallreq_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                data_avail     = mem_memreq_i & data_ok_i;
                mem_stallreq_o = mem_memreq_i & ~data_ok_i;
                if (data_avail)
                    buf_d = data_rdata_i;
                if (mem_memreq_i & ~data_ok_i)
                    state_d = mem_flush_i ? ST_DROP : ST_WAIT;
                else if (data_avail & mem_stall_i & ~mem_flush_i)
                    state_d = ST_HOLD;
            end
            ST_WAIT: begin
                data_avail     = data_ok_i;
                mem_stallreq_o = ~data_ok_i;
                if (data_ok_i)
                    buf_d = data_rdata_i;
                if (mem_flush_i)
                    state_d = data_ok_i ? ST_IDLE : ST_DROP;
                else if (data_ok_i)
                    state_d = mem_stall_i ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                data_avail = 1'b1;
                if (mem_flush_i | ~mem_stall_i)
                    state_d = ST_IDLE;
            end
            ST_DROP: begin
                if (data_ok_i)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A flushed instruction, or the one whose response is being discarded, writes nothing.
    assign kill    = mem_flush_i | (state_q == ST_DROP);
    assign upd     = ~mem_stall_i & ~mem_stallreq_o;
    assign wren_d  = kill ? '0 : mem_wren_i;
    assign waddr_d = kill ? '0 : mem_waddr_i;
    assign wdata_d = kill ? '0 : (is_ld ? aligned : mem_wdata_i);

    assign mem_wdata_bp_o = (is_ld & data_avail) ? aligned : mem_wdata_i;
    assign mem_nofwd_bp_o = mem_nofwd_i | (is_ld & ~data_avail);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            wren_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            if (upd) begin
                wren_q  <= wren_d;
                waddr_q <= waddr_d;
                wdata_q <= wdata_d;
            end
        end
    end

    assign mem_wren_o  = wren_q;
    assign mem_waddr_o = waddr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have ports: clk in 1, pipeline clock; rst_n in 1, reset, asynchronous and active-low.
REQ-002 SHALL have ports: mem_flush_i in 1, kill the current MEM instruction; mem_stall_i in 1, downstream hold.
REQ-003 SHALL have ports from EX: mem_wren_i in 4, mem_waddr_i in 5, mem_wdata_i in 32 (ALU result), mem_nofwd_i in 1.
REQ-004 SHALL have ports from EX: mem_memop_i in MMOP (12), mem_memaddr_low_i in 2, mem_rtvalue_i in 32, mem_memreq_i in 1 (bus request issued in EX).
REQ-005 SHALL have bus ports: data_rdata_i in 32; data_ok_i in 1, one-cycle response pulse.
REQ-006 SHALL have output ports: mem_wren_o 4, mem_waddr_o 5, mem_wdata_o 32, registered to WB.
REQ-007 SHALL have output ports: mem_stallreq_o 1, mem_wdata_bp_o 32, mem_nofwd_bp_o 1, all combinational bypass/stall.

Function
REQ-008 SHALL implement FSM states IDLE, WAIT, HOLD and DROP.
REQ-009 IDLE: if mem_memreq_i & ~data_ok_i, SHALL go to WAIT; if request and data_ok_i arrive in the same cycle, SHALL complete with zero wait.
REQ-010 WAIT: on data_ok_i, SHALL capture data_rdata_i; go to IDLE if ~mem_stall_i, else to HOLD.
REQ-011 HOLD: SHALL keep the captured word in a 32-bit buffer and return to IDLE when mem_stall_i drops.
REQ-012 mem_stallreq_o SHALL be 1 in WAIT, and in IDLE while a request is pending without data_ok_i; 0 otherwise.
REQ-013 mem_flush_i in WAIT SHALL go to DROP, absorb exactly one data_ok_i, then return to IDLE with no write.
REQ-014 mem_flush_i in IDLE or HOLD SHALL zero the next-stage register inputs (wren, waddr, wdata).
REQ-015 Load alignment, little-endian on mem_memaddr_low_i: lb/lbu select byte[low] with sign/zero extension; lh/lhu select half[low[1]] with sign/zero extension; lw passes the word.
REQ-016 lwl SHALL merge by low: 0={rd[7:0],rt[23:0]}, 1={rd[15:0],rt[15:0]}, 2={rd[23:0],rt[7:0]}, 3=rd.
REQ-017 lwr SHALL merge by low: 0=rd, 1={rt[31:24],rd[31:8]}, 2={rt[31:16],rd[31:16]}, 3={rt[31:8],rd[31:24]}.
REQ-018 Non-load instructions (including stores) SHALL forward mem_wdata_i; stores SHALL still wait for data_ok_i.
REQ-019 The pipeline register SHALL update only when ~mem_stall_i & ~mem_stallreq_o, with latency 1 cycle after the response.
REQ-020 mem_wdata_bp_o SHALL give the aligned data when load data is available, else mem_wdata_i.
REQ-021 mem_nofwd_bp_o SHALL be mem_nofwd_i | (load & data not yet available).

Reset
REQ-022 rst_n low SHALL asynchronously force state IDLE and clear the buffer and all registered outputs to 0.
REQ-023 A reset during WAIT SHALL abandon the pending response; the bus is reset by the same rst_n.

Configuration
REQ-024 With UNALIGNED_LS_EN defined, SHALL implement the lwl/lwr merges of REQ-016/017.
REQ-025 Without UNALIGNED_LS_EN, SHALL ignore memop bits 8 and 9, and the rtvalue merge logic is absent.

Structure
REQ-026 MMOP width, memop bit indices and FSM state encodings SHALL live in defines.v.
REQ-027 Alignment SHALL be a combinational sub-module load_align.
REQ-028 Registers SHALL use the existing DFFRE cell.

Verification
REQ-029 lb at low=3, rdata=0x80112233 -> mem_wdata_o=0xFFFFFF80; lbu at low=3 -> 0x00000080.
REQ-030 lh, low=2, data_ok after 3 cycles -> stallreq high 3 cycles, then wdata=0xFFFF8011 for rdata=0x80112233.
REQ-031 lwl low=1, rt=0xAABBCCDD, rdata=0x11223344 -> 0x3344CCDD; lwr low=1 -> 0xAA112233.
REQ-032 flush during WAIT, then data_ok -> DROP, no wren, IDLE next cycle.
REQ-033 data_ok while mem_stall_i=1 -> HOLD retains 0x11223344 until stall release, then WB receives it once.
